// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode trap sequencer for the pipelined RV32I core.
//               Classifies interrupts, ecall, ebreak, mret and illegal
//               instructions at commit, stalls/flushes the pipeline, writes
//               mepc/mcause/mtval/mstatus one per cycle through the CSR trap
//               port, then redirects fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
    parameter int VECTORED_EN = 1,
    parameter int IRQ_SYNC    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic [31:0] commit_inst,
    input  logic        commit_invalid,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic [31:0] csr_mstatus,
    input  logic [31:0] csr_mie,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic        trap_csr_we,
    output logic [11:0] trap_csr_addr,
    output logic [31:0] trap_csr_wdata,
    output logic        stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [2:0]  c_st_idle    = 3'd0;
    localparam logic [2:0]  c_st_w_epc   = 3'd1;
    localparam logic [2:0]  c_st_w_cause = 3'd2;
    localparam logic [2:0]  c_st_w_tval  = 3'd3;
    localparam logic [2:0]  c_st_w_stat  = 3'd4;
    localparam logic [2:0]  c_st_m_stat  = 3'd5;
    localparam logic [2:0]  c_st_redir   = 3'd6;

    localparam logic [11:0] c_addr_mstatus = 12'h300;
    localparam logic [11:0] c_addr_mepc    = 12'h341;
    localparam logic [11:0] c_addr_mcause  = 12'h342;
    localparam logic [11:0] c_addr_mtval   = 12'h343;

    localparam logic [31:0] c_inst_ecall  = 32'h0000_0073;
    localparam logic [31:0] c_inst_ebreak = 32'h0010_0073;
    localparam logic [31:0] c_inst_mret   = 32'h3020_0073;

    localparam logic [31:0] c_cause_irq_ext = 32'h8000_000B;
    localparam logic [31:0] c_cause_irq_tmr = 32'h8000_0007;
    localparam logic [31:0] c_cause_ecall   = 32'd11;
    localparam logic [31:0] c_cause_ebreak  = 32'd3;
    localparam logic [31:0] c_cause_illegal = 32'd2;

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_cause;
    logic [31:0] r_tval;
    logic        r_is_irq;
    logic        r_is_mret;

    logic        w_irq_ext_s;
    logic        w_irq_tmr_s;
    logic        w_take_ext;
    logic        w_take_tmr;
    logic        w_is_ecall;
    logic        w_is_ebreak;
    logic        w_is_mret;
    logic        w_detect;
    logic [31:0] w_cause;
    logic [31:0] w_tval;
    logic        w_kind_irq;
    logic        w_kind_mret;
    logic [31:0] w_mstatus_trap;
    logic [31:0] w_mstatus_mret;
    logic        w_vectored;
    logic [31:0] w_trap_target;
    logic        w_unused;

    generate
        if (IRQ_SYNC == 0) begin : g_irq_bypass
            assign w_irq_ext_s = irq_ext;
            assign w_irq_tmr_s = irq_timer;
        end else begin : g_irq_sync
            logic [IRQ_SYNC-1:0] r_ext_sync;
            logic [IRQ_SYNC-1:0] r_tmr_sync;

            // Pass both level interrupt requests through a flop chain
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ext_sync <= '0;
                    r_tmr_sync <= '0;
                end else begin
                    r_ext_sync[0] <= irq_ext;
                    r_tmr_sync[0] <= irq_timer;
                    for (int i = 1; i < IRQ_SYNC; i++) begin
                        r_ext_sync[i] <= r_ext_sync[i-1];
                        r_tmr_sync[i] <= r_tmr_sync[i-1];
                    end
                end
            end

            assign w_irq_ext_s = r_ext_sync[IRQ_SYNC-1];
            assign w_irq_tmr_s = r_tmr_sync[IRQ_SYNC-1];
        end
    endgenerate

    assign w_take_ext  = w_irq_ext_s & csr_mstatus[3] & csr_mie[11];
    assign w_take_tmr  = w_irq_tmr_s & csr_mstatus[3] & csr_mie[7];
    assign w_is_ecall  = commit_invalid & (commit_inst == c_inst_ecall);
    assign w_is_ebreak = commit_invalid & (commit_inst == c_inst_ebreak);
    assign w_is_mret   = commit_invalid & (commit_inst == c_inst_mret);

    // Interrupts and exceptions are only recognised on a valid commit in IDLE
    assign w_detect = ~rst & (r_state == c_st_idle) & commit_valid
                    & (w_take_ext | w_take_tmr | commit_invalid);

    // Priority classification of the commit-stage event
    always_comb begin
        w_cause     = '0;
        w_tval      = '0;
        w_kind_irq  = 1'b0;
        w_kind_mret = 1'b0;
        if (w_take_ext) begin
            w_cause    = c_cause_irq_ext;
            w_kind_irq = 1'b1;
        end else if (w_take_tmr) begin
            w_cause    = c_cause_irq_tmr;
            w_kind_irq = 1'b1;
        end else if (w_is_ecall) begin
            w_cause = c_cause_ecall;
        end else if (w_is_ebreak) begin
            w_cause = c_cause_ebreak;
        end else if (w_is_mret) begin
            w_kind_mret = 1'b1;
        end else begin
            w_cause = c_cause_illegal;
            w_tval  = commit_inst;
        end
    end

    // Sequencer: latch trap context on detect, then walk the CSR writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_pc      <= '0;
            r_cause   <= '0;
            r_tval    <= '0;
            r_is_irq  <= 1'b0;
            r_is_mret <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_detect) begin
                        r_pc      <= {commit_pc[31:2], 2'b00};
                        r_cause   <= w_cause;
                        r_tval    <= w_tval;
                        r_is_irq  <= w_kind_irq;
                        r_is_mret <= w_kind_mret;
                        r_state   <= w_kind_mret ? c_st_m_stat : c_st_w_epc;
                    end
                end
                c_st_w_epc:   r_state <= c_st_w_cause;
                c_st_w_cause: r_state <= c_st_w_tval;
                c_st_w_tval:  r_state <= c_st_w_stat;
                c_st_w_stat:  r_state <= c_st_redir;
                c_st_m_stat:  r_state <= c_st_redir;
                c_st_redir:   r_state <= c_st_idle;
                default:      r_state <= c_st_idle;
            endcase
        end
    end

    // mstatus images for trap entry and mret, built from the live CSR value
    always_comb begin
        w_mstatus_trap        = csr_mstatus;
        w_mstatus_trap[7]     = csr_mstatus[3];
        w_mstatus_trap[3]     = 1'b0;
        w_mstatus_trap[12:11] = 2'b11;
        w_mstatus_mret        = csr_mstatus;
        w_mstatus_mret[3]     = csr_mstatus[7];
        w_mstatus_mret[7]     = 1'b1;
        w_mstatus_mret[12:11] = 2'b11;
    end

    // Vectored mode only applies to interrupts; exceptions always go to base
    assign w_vectored    = (VECTORED_EN != 0) && (csr_mtvec[1:0] == 2'b01) && r_is_irq;
    assign w_trap_target = {csr_mtvec[31:2], 2'b00}
                         + (w_vectored ? {25'd0, r_cause[4:0], 2'b00} : 32'd0);

    // Output decode from the sequencer state; reset silences everything
    always_comb begin
        trap_csr_we    = 1'b0;
        trap_csr_addr  = '0;
        trap_csr_wdata = '0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (!rst) begin
            case (r_state)
                c_st_idle: begin
                    stall = w_detect;
                    flush = w_detect;
                end
                c_st_w_epc: begin
                    stall          = 1'b1;
                    trap_csr_we    = 1'b1;
                    trap_csr_addr  = c_addr_mepc;
                    trap_csr_wdata = r_pc;
                end
                c_st_w_cause: begin
                    stall          = 1'b1;
                    trap_csr_we    = 1'b1;
                    trap_csr_addr  = c_addr_mcause;
                    trap_csr_wdata = r_cause;
                end
                c_st_w_tval: begin
                    stall          = 1'b1;
                    trap_csr_we    = 1'b1;
                    trap_csr_addr  = c_addr_mtval;
                    trap_csr_wdata = r_tval;
                end
                c_st_w_stat: begin
                    stall          = 1'b1;
                    trap_csr_we    = 1'b1;
                    trap_csr_addr  = c_addr_mstatus;
                    trap_csr_wdata = w_mstatus_trap;
                end
                c_st_m_stat: begin
                    stall          = 1'b1;
                    trap_csr_we    = 1'b1;
                    trap_csr_addr  = c_addr_mstatus;
                    trap_csr_wdata = w_mstatus_mret;
                end
                c_st_redir: begin
                    stall          = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = r_is_mret ? {csr_mepc[31:2], 2'b00} : w_trap_target;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    assign w_unused = ^{commit_pc[1:0], csr_mie[31:12], csr_mie[10:8], csr_mie[6:0],
                        csr_mepc[1:0]};

endmodule
`default_nettype wire
